// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the M-extension operations
//   - FSM state enum (2 bits)
//   - CALC_CYCLES: number of iterations of the shared datapath
//   - helpers deciding which operands are interpreted as signed
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int CALC_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rs1 is unsigned only for MULHU, DIVU and REMU
    function automatic logic op1_is_signed(input logic [2:0] f3);
        return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
    endfunction

    // rs2 is additionally unsigned for MULHSU
    function automatic logic op2_is_signed(input logic [2:0] f3);
        return op1_is_signed(f3) && (f3 != F3_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One shared datapath: a 64-bit accumulator/remainder shift register,
// a 32-bit operand register and two sign flags. Multiply is radix-2
// shift-add on magnitudes; divide is restoring, one quotient bit per cycle.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      execute stage holds an M instruction, operands valid
//   funct3     operation select (MUL..REMU)
//   operand1   rs1 value
//   operand2   rs2 value
//   flush      squash of the execute stage
//   result     registered result, valid while done=1, held afterwards
//   done       one-cycle result-valid pulse
//   stall      freezes the front of the pipeline while high
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        flush,
    output logic [31:0] result,
    output logic        done,
    output logic        stall
);

    state_t      state_reg,  state_next;
    logic [4:0]  count_reg,  count_next;
    logic [63:0] acc_reg,    acc_next;
    logic [31:0] opnd_reg,   opnd_next;
    logic [2:0]  f3_reg,     f3_next;
    logic        sign1_reg,  sign1_next;
    logic        sign2_reg,  sign2_next;
    logic [31:0] result_reg, result_next;

    // ---------------- entry decode ----------------
    logic        accept;
    logic        in_sign1, in_sign2;
    logic [31:0] abs1, abs2;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;

    assign accept   = (state_reg == ST_IDLE) && start && !flush;
    assign in_sign1 = op1_is_signed(funct3) && operand1[31];
    assign in_sign2 = op2_is_signed(funct3) && operand2[31];
    assign abs1     = in_sign1 ? -operand1 : operand1;
    assign abs2     = in_sign2 ? -operand2 : operand2;

    assign div_zero = funct3[2] && (operand2 == 32'd0);
    // signed overflow exists only for DIV/REM (funct3[0]=0 among divides)
    assign div_ovf  = funct3[2] && !funct3[0] &&
                      (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = funct3[1] ? operand1 : 32'hFFFF_FFFF;
        else
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // ---------------- iteration step ----------------
    // Multiply: low half holds the remaining multiplier bits, high half
    // accumulates; the carry of the add shifts in from the top.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign mul_step = {mul_sum, acc_reg[31:1]};

    // Divide: high half is the partial remainder, low half shifts the
    // dividend out and the quotient bits in. The trial remainder needs
    // 33 bits because the shifted remainder can exceed 2^32-1.
    logic [32:0] rem_trial, rem_diff;
    logic        rem_ge;
    logic [63:0] div_step;
    assign rem_trial = {acc_reg[63:32], acc_reg[31]};
    assign rem_ge    = rem_trial >= {1'b0, opnd_reg};
    assign rem_diff  = rem_trial - {1'b0, opnd_reg};
    assign div_step  = {(rem_ge ? rem_diff[31:0] : rem_trial[31:0]), acc_reg[30:0], rem_ge};

    logic [63:0] acc_step;
    assign acc_step = f3_reg[2] ? div_step : mul_step;

    // ---------------- final sign fix-up ----------------
    logic [63:0] product;
    logic [31:0] quotient, remainder, final_res;
    assign product   = (sign1_reg ^ sign2_reg) ? -acc_step : acc_step;
    assign quotient  = (sign1_reg ^ sign2_reg) ? -acc_step[31:0] : acc_step[31:0];
    assign remainder = sign1_reg ? -acc_step[63:32] : acc_step[63:32];

    always_comb begin
        final_res = 32'd0;
        case (f3_reg)
            F3_MUL:                         final_res = product[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   final_res = product[63:32];
            F3_DIV, F3_DIVU:                final_res = quotient;
            default:                        final_res = remainder;
        endcase
    end

    logic last_iter;
    assign last_iter = (count_reg == 5'(CALC_CYCLES - 1));

    // ---------------- FSM next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    state_next = (div_zero || div_ovf) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (flush)
                    state_next = ST_IDLE;
                else if (last_iter)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;   // start and flush both ignored here
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        count_next  = count_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        f3_next     = f3_reg;
        sign1_next  = sign1_reg;
        sign2_next  = sign2_reg;
        result_next = result_reg;

        if (accept) begin
            count_next = 5'd0;
            f3_next    = funct3;
            sign1_next = in_sign1;
            sign2_next = in_sign2;
            // divide iterates the dividend against the divisor,
            // multiply iterates the multiplier bits of rs2 against rs1
            acc_next   = {32'd0, funct3[2] ? abs1 : abs2};
            opnd_next  = funct3[2] ? abs2 : abs1;
            if (div_zero || div_ovf)
                result_next = special_res;
        end else if (state_reg == ST_CALC && !flush) begin
            acc_next   = acc_step;
            count_next = count_reg + 5'd1;
            if (last_iter)
                result_next = final_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 5'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            f3_reg     <= 3'd0;
            sign1_reg  <= 1'b0;
            sign2_reg  <= 1'b0;
            result_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            f3_reg     <= f3_next;
            sign1_reg  <= sign1_next;
            sign2_reg  <= sign2_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;
    assign done   = (state_reg == ST_DONE);
    assign stall  = accept || (state_reg == ST_CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: stimulus pushes the expected result
// and the cycle at which done must appear; a monitor on the falling edge
// pops and compares whenever done is high.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        stall;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .result   (result),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] last_res   = 32'd0;
    string       op_names[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

    // Reference model: plain 64-bit arithmetic on the ISA definitions
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, ub, p;
        logic        [63:0] up;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sbv; return p[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.res || cyc != e.due || stall !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s %h,%h: result=%h cycle=%0d stall=%b, required result=%h cycle=%0d stall=0",
                             op_names[e.op], e.a, e.b, result, cyc, stall, e.res, e.due);
                end else begin
                    $display("ok   %-6s %h,%h -> %h at cycle %0d", op_names[e.op], e.a, e.b, result, cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Called at posedge+1: presents one instruction for one edge
    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic fast;
        exp_t e;
        funct3   = f;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        fast     = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.res = ref_model(f, a, b);
        e.due = cyc + (fast ? 1 : 33);
        e.op  = int'(f);
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        last_res = e.res;
        #1;
        check("stall_on_start", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int          bad;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; operand1 = 32'd0; operand2 = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_result", result, 32'd0);
        check("reset_done",  {31'd0, done},  32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // MUL with stall held for the whole calculation
        drive(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (stall !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("stall_through_calc", 32'(bad), 32'd0);
        wait_drain();

        drive(F3_MULH,   32'h8000_0000, 32'h8000_0000); wait_drain();
        drive(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_drain();
        drive(F3_MULHSU, 32'hFFFF_FFFF, 32'd2);         wait_drain();
        drive(F3_DIV,    32'hFFFF_FFF9, 32'd2);         wait_drain();
        drive(F3_REM,    32'hFFFF_FFF9, 32'd2);         wait_drain();
        drive(F3_DIVU,   32'd100, 32'd7);               wait_drain();
        drive(F3_REMU,   32'd100, 32'd7);               wait_drain();
        drive(F3_DIVU,   32'h1234, 32'd0);              wait_drain();
        drive(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
        drive(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
        drive(F3_REMU,   32'hDEAD_BEEF, 32'd0);         wait_drain();
        check("result_hold", result, last_res);

        // start during CALC is ignored
        drive(F3_DIVU, 32'd1000, 32'd33);
        funct3 = F3_MUL; operand1 = 32'd3; operand2 = 32'd5; start = 1'b1;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        wait_drain();

        // start and flush while in DONE are both ignored
        drive(F3_MUL, 32'h0001_0003, 32'h0000_0101);
        repeat (32) @(posedge clk);
        #1;
        funct3 = F3_MULHU; operand1 = 32'hFFFF_0000; operand2 = 32'h1234_5678;
        start = 1'b1; flush = 1'b1;
        #1 check("stall_in_done", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        wait_drain();
        repeat (40) @(posedge clk);
        #1 check("hold_after_done", result, last_res);

        // start together with flush in IDLE is not accepted
        funct3 = F3_MUL; operand1 = 32'd9; operand2 = 32'd9; start = 1'b1; flush = 1'b1;
        #1 check("stall_flush_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // flush mid-CALC, then a fresh start
        prev = last_res;
        drive(F3_MUL, 32'h0BAD_F00D, 32'h0000_1235);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_done",  {31'd0, done},  32'd0);
        check("flush_result", result, prev);
        @(posedge clk); #1;
        drive(F3_MUL, 32'd123456, 32'd654321);
        wait_drain();

        // reset in the middle of a divide
        prev = last_res;
        drive(F3_DIV, 32'h7654_3210, 32'hFFFF_FF13);
        repeat (19) @(posedge clk);
        #1 check("result_before_reset", result, prev);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check("reset_mid_result", result, 32'd0);
        check("reset_mid_done",  {31'd0, done},  32'd0);
        check("reset_mid_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            drive(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
